// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I 5-stage core: operand forwarding, ALU operand select,
// load-use stall detection and bubble injection on stall or flush.
module id_ex_stage #(
    parameter int unsigned XLEN        = 32,
    parameter logic [3:0]  NOP_ALUCTRL = 4'b0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [XLEN-1:0] rs1_data_d,
    input  logic [XLEN-1:0] rs2_data_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [3:0]      alucontrol_d,
    input  logic            alusrca_d,
    input  logic            alusrcb_d,
    input  logic            regwrite_d,
    input  logic            memread_d,
    input  logic            memwrite_d,
    input  logic [1:0]      resultsrc_d,
    input  logic            flush_e,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_regwrite,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_regwrite,
    input  logic [XLEN-1:0] memwb_result,
    output logic            stall_d,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alucontrol_e,
    output logic [XLEN-1:0] storedata_e,
    output logic [4:0]      rd_e,
    output logic [XLEN-1:0] pc_e,
    output logic            valid_e,
    output logic            regwrite_e,
    output logic            memread_e,
    output logic            memwrite_e,
    output logic [1:0]      resultsrc_e,
    output logic [1:0]      fwda_e,
    output logic [1:0]      fwdb_e
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      resultsrc;
        logic            alusrca;
        logic            alusrcb;
        logic [3:0]      alucontrol;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } ex_t;

    ex_t ex_q, ex_d, bubble;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // Bubble is also the reset image: everything zero except the NOP ALU code.
    always_comb begin
        bubble            = '0;
        bubble.alucontrol = NOP_ALUCTRL;
    end

    // rs1 is only a real source when the ALU takes it (auipc/jal use PC instead).
    always_comb begin
        stall_d = ex_q.memread & ex_q.valid & (ex_q.rd != 5'd0) & valid_d &
                  (((ex_q.rd == rs1_d) & ~alusrca_d) | (ex_q.rd == rs2_d));
    end

    always_comb begin
        ex_d = bubble;
        if (!flush_e && !stall_d) begin
            ex_d.valid      = valid_d;
            ex_d.regwrite   = regwrite_d;
            ex_d.memread    = memread_d;
            ex_d.memwrite   = memwrite_d;
            ex_d.resultsrc  = resultsrc_d;
            ex_d.alusrca    = alusrca_d;
            ex_d.alusrcb    = alusrcb_d;
            ex_d.alucontrol = alucontrol_d;
            ex_d.rd         = rd_d;
            ex_d.rs1        = rs1_d;
            ex_d.rs2        = rs2_d;
            ex_d.rs1_data   = rs1_data_d;
            ex_d.rs2_data   = rs2_data_d;
            ex_d.imm        = imm_d;
            ex_d.pc         = pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    // EX/MEM wins over MEM/WB; x0 is never forwarded.
    always_comb begin
        fwda_e = 2'b00;
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == ex_q.rs1) begin
            fwda_e = 2'b10;
        end else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == ex_q.rs1) begin
            fwda_e = 2'b01;
        end
        fwdb_e = 2'b00;
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == ex_q.rs2) begin
            fwdb_e = 2'b10;
        end else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == ex_q.rs2) begin
            fwdb_e = 2'b01;
        end
    end

    always_comb begin
        unique case (fwda_e)
            2'b10:   fwd_rs1 = exmem_result;
            2'b01:   fwd_rs1 = memwb_result;
            default: fwd_rs1 = ex_q.rs1_data;
        endcase
        unique case (fwdb_e)
            2'b10:   fwd_rs2 = exmem_result;
            2'b01:   fwd_rs2 = memwb_result;
            default: fwd_rs2 = ex_q.rs2_data;
        endcase
    end

    assign alu_a        = ex_q.alusrca ? ex_q.pc  : fwd_rs1;
    assign alu_b        = ex_q.alusrcb ? ex_q.imm : fwd_rs2;
    assign storedata_e  = fwd_rs2;
    assign alucontrol_e = ex_q.alucontrol;
    assign rd_e         = ex_q.rd;
    assign pc_e         = ex_q.pc;
    assign valid_e      = ex_q.valid;
    assign regwrite_e   = ex_q.regwrite;
    assign memread_e    = ex_q.memread;
    assign memwrite_e   = ex_q.memwrite;
    assign resultsrc_e  = ex_q.resultsrc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding, operand select, load-use stall,
// flush/stall bubble and asynchronous reset.
module tb_id_ex_stage;

    logic        clk;
    logic        reset;
    logic        valid_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] rs1_data_d, rs2_data_d, imm_d, pc_d;
    logic [3:0]  alucontrol_d;
    logic        alusrca_d, alusrcb_d, regwrite_d, memread_d, memwrite_d;
    logic [1:0]  resultsrc_d;
    logic        flush_e;
    logic [4:0]  exmem_rd;
    logic        exmem_regwrite;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_regwrite;
    logic [31:0] memwb_result;
    logic        stall_d;
    logic [31:0] alu_a, alu_b, storedata_e, pc_e;
    logic [3:0]  alucontrol_e;
    logic [4:0]  rd_e;
    logic        valid_e, regwrite_e, memread_e, memwrite_e;
    logic [1:0]  resultsrc_e, fwda_e, fwdb_e;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32), .NOP_ALUCTRL(4'b0000)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d), .pc_d(pc_d),
        .alucontrol_d(alucontrol_d), .alusrca_d(alusrca_d), .alusrcb_d(alusrcb_d),
        .regwrite_d(regwrite_d), .memread_d(memread_d), .memwrite_d(memwrite_d),
        .resultsrc_d(resultsrc_d), .flush_e(flush_e),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
        .stall_d(stall_d), .alu_a(alu_a), .alu_b(alu_b), .alucontrol_e(alucontrol_e),
        .storedata_e(storedata_e), .rd_e(rd_e), .pc_e(pc_e), .valid_e(valid_e),
        .regwrite_e(regwrite_e), .memread_e(memread_e), .memwrite_e(memwrite_e),
        .resultsrc_e(resultsrc_e), .fwda_e(fwda_e), .fwdb_e(fwdb_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        valid_d      = 1'b0;
        rs1_d        = 5'd0;
        rs2_d        = 5'd0;
        rd_d         = 5'd0;
        rs1_data_d   = 32'd0;
        rs2_data_d   = 32'd0;
        imm_d        = 32'd0;
        pc_d         = 32'd0;
        alucontrol_d = 4'b0000;
        alusrca_d    = 1'b0;
        alusrcb_d    = 1'b0;
        regwrite_d   = 1'b0;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;
        resultsrc_d  = 2'b00;
    endtask

    initial begin
        reset          = 1'b1;
        flush_e        = 1'b0;
        exmem_rd       = 5'd0;
        exmem_regwrite = 1'b0;
        exmem_result   = 32'd0;
        memwb_rd       = 5'd0;
        memwb_regwrite = 1'b0;
        memwb_result   = 32'd0;
        clear_id();
        #3;
        check("rst_valid_e", 32'(valid_e), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_storedata", storedata_e, 32'd0);
        check("rst_stall", 32'(stall_d), 32'd0);
        check("rst_aluctl", 32'(alucontrol_e), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // add x3,x1,x2
        valid_d = 1'b1; rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd3;
        rs1_data_d = 32'd5; rs2_data_d = 32'd7; regwrite_d = 1'b1; pc_d = 32'h100;
        tick();
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_aluctl", 32'(alucontrol_e), 32'd0);
        check("add_fwda", 32'(fwda_e), 32'd0);
        check("add_fwdb", 32'(fwdb_e), 32'd0);
        check("add_valid_e", 32'(valid_e), 32'd1);
        check("add_rd_e", 32'(rd_e), 32'd3);
        check("add_pc_e", pc_e, 32'h100);
        check("add_regwrite_e", 32'(regwrite_e), 32'd1);

        // Both stages target x1; EX/MEM must win, then MEM/WB alone
        exmem_rd = 5'd1; exmem_regwrite = 1'b1; exmem_result = 32'h10;
        memwb_rd = 5'd1; memwb_regwrite = 1'b1; memwb_result = 32'h20;
        #1;
        check("fwd_exmem_alu_a", alu_a, 32'h10);
        check("fwd_exmem_fwda", 32'(fwda_e), 32'd2);
        check("fwd_exmem_alu_b", alu_b, 32'd7);
        exmem_regwrite = 1'b0;
        #1;
        check("fwd_memwb_alu_a", alu_a, 32'h20);
        check("fwd_memwb_fwda", 32'(fwda_e), 32'd1);

        // x0 must never be forwarded
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd0; rs2_d = 5'd2; rd_d = 5'd4;
        rs1_data_d = 32'h33; rs2_data_d = 32'h7; regwrite_d = 1'b1;
        exmem_rd = 5'd0; exmem_regwrite = 1'b1; exmem_result = 32'hFF;
        memwb_regwrite = 1'b0;
        tick();
        check("x0_fwda", 32'(fwda_e), 32'd0);
        check("x0_alu_a", alu_a, 32'h33);
        memwb_rd = 5'd0; memwb_regwrite = 1'b1; memwb_result = 32'hEE;
        #1;
        check("x0_memwb_fwda", 32'(fwda_e), 32'd0);
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;

        // lw x5,4(x1) into EX
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd1; rd_d = 5'd5; rs1_data_d = 32'h1000; imm_d = 32'd4;
        alusrcb_d = 1'b1; memread_d = 1'b1; regwrite_d = 1'b1; resultsrc_d = 2'b01;
        #1;
        check("pre_lw_stall", 32'(stall_d), 32'd0);
        tick();
        check("lw_memread_e", 32'(memread_e), 32'd1);
        check("lw_alu_a", alu_a, 32'h1000);
        check("lw_alu_b", alu_b, 32'd4);
        check("lw_resultsrc_e", 32'(resultsrc_e), 32'd1);
        // add x6,x5,x0 in ID -> load-use
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd5; rs2_d = 5'd0; rd_d = 5'd6; regwrite_d = 1'b1;
        #1;
        check("lu_stall", 32'(stall_d), 32'd1);
        tick();
        check("lu_bubble_valid", 32'(valid_e), 32'd0);
        check("lu_bubble_regwrite", 32'(regwrite_e), 32'd0);
        check("lu_bubble_memread", 32'(memread_e), 32'd0);
        check("lu_stall_drop", 32'(stall_d), 32'd0);
        memwb_rd = 5'd5; memwb_regwrite = 1'b1; memwb_result = 32'hABCD;
        tick();
        check("lu_add_valid", 32'(valid_e), 32'd1);
        check("lu_add_rd", 32'(rd_e), 32'd6);
        check("lu_add_fwda", 32'(fwda_e), 32'd1);
        check("lu_add_alu_a", alu_a, 32'hABCD);
        check("lu_add_fwdb", 32'(fwdb_e), 32'd0);
        check("lu_add_alu_b", alu_b, 32'd0);

        // sw x5,8(x1) with x5 forwarded from EX/MEM
        clear_id();
        memwb_regwrite = 1'b0;
        valid_d = 1'b1; rs1_d = 5'd1; rs2_d = 5'd5; rs1_data_d = 32'h200; rs2_data_d = 32'h11;
        imm_d = 32'd8; alusrcb_d = 1'b1; memwrite_d = 1'b1;
        exmem_rd = 5'd5; exmem_regwrite = 1'b1; exmem_result = 32'h55;
        tick();
        check("sw_alu_b", alu_b, 32'd8);
        check("sw_storedata", storedata_e, 32'h55);
        check("sw_fwdb", 32'(fwdb_e), 32'd2);
        check("sw_alu_a", alu_a, 32'h200);
        check("sw_memwrite_e", 32'(memwrite_e), 32'd1);
        exmem_regwrite = 1'b0;
        #1;
        check("sw_storedata_nofwd", storedata_e, 32'h11);

        // lw x7 then dependent add with flush in the same cycle -> one bubble only
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd2; rd_d = 5'd7; alusrcb_d = 1'b1;
        memread_d = 1'b1; regwrite_d = 1'b1;
        tick();
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd7; rs2_d = 5'd7; rd_d = 5'd8; regwrite_d = 1'b1;
        alucontrol_d = 4'b1000;
        #1;
        check("fs_stall", 32'(stall_d), 32'd1);
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        check("fs_bubble_valid", 32'(valid_e), 32'd0);
        check("fs_bubble_memread", 32'(memread_e), 32'd0);
        check("fs_bubble_rd", 32'(rd_e), 32'd0);
        check("fs_bubble_aluctl", 32'(alucontrol_e), 32'd0);
        check("fs_stall_drop", 32'(stall_d), 32'd0);
        tick();
        check("fs_add_valid", 32'(valid_e), 32'd1);
        check("fs_add_rd", 32'(rd_e), 32'd8);
        check("fs_add_aluctl", 32'(alucontrol_e), 32'h8);

        // Flush alone on a non-hazard instruction
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd3; rd_d = 5'd10; regwrite_d = 1'b1; alucontrol_d = 4'b0101;
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        check("flush_valid", 32'(valid_e), 32'd0);
        check("flush_regwrite", 32'(regwrite_e), 32'd0);

        // Asynchronous reset in the middle of a stall cycle
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd1; rd_d = 5'd9; rs1_data_d = 32'h77; imm_d = 32'h4;
        alusrcb_d = 1'b1; memread_d = 1'b1; regwrite_d = 1'b1;
        tick();
        clear_id();
        valid_d = 1'b1; rs1_d = 5'd9; rd_d = 5'd11; regwrite_d = 1'b1;
        #1;
        check("ar_pre_stall", 32'(stall_d), 32'd1);
        check("ar_pre_valid", 32'(valid_e), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(valid_e), 32'd0);
        check("ar_stall", 32'(stall_d), 32'd0);
        check("ar_alu_a", alu_a, 32'd0);
        check("ar_alu_b", alu_b, 32'd0);
        check("ar_storedata", storedata_e, 32'd0);
        check("ar_rd", 32'(rd_e), 32'd0);
        check("ar_memread", 32'(memread_e), 32'd0);
        check("ar_regwrite", 32'(regwrite_e), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Registers decoded instruction fields from the ID stage into the EX stage. This is the ID/EX pipeline register of the RV32I 5-stage core.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Selects the final ALU a/b operands and 4-bit alucontrol that drive the ALU.
- Detects load-use hazards: stalls ID and injects a bubble into EX; honours a flush request from downstream branch logic.

Parameters:
XLEN, 32, datapath width
NOP_ALUCTRL, 4'b0000, alucontrol value held by a bubble (add)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
valid_d  input  1  ID holds a real instruction
rs1_d, rs2_d, rd_d  input  5 each  decoded register indices
rs1_data_d, rs2_data_d  input  XLEN each  register-file read data
imm_d  input  XLEN  sign-extended immediate
pc_d  input  XLEN  instruction PC
alucontrol_d  input  4  ALU operation code
alusrca_d  input  1  1: a = PC, 0: a = rs1
alusrcb_d  input  1  1: b = imm, 0: b = rs2
regwrite_d, memread_d, memwrite_d  input  1 each  control bits
resultsrc_d  input  2  writeback select
flush_e  input  1  discard the instruction entering EX
exmem_rd  input  5  EX/MEM destination
exmem_regwrite  input  1  EX/MEM writes a register
exmem_result  input  XLEN  EX/MEM ALU result
memwb_rd  input  5  MEM/WB destination
memwb_regwrite  input  1  MEM/WB writes a register
memwb_result  input  XLEN  MEM/WB writeback value
stall_d  output  1  hold PC and IF/ID this cycle
alu_a, alu_b  output  XLEN each  ALU operands
alucontrol_e  output  4  to ALU
storedata_e  output  XLEN  forwarded rs2 for stores
rd_e  output  5  EX destination
pc_e  output  XLEN  EX PC
valid_e, regwrite_e, memread_e, memwrite_e  output  1 each
resultsrc_e  output  2
fwda_e, fwdb_e  output  2 each  forward selects (debug/coverage)

Behaviour:
Reset
- On reset, all EX registers clear asynchronously to 0, including valid, control bits and indices.
- alucontrol_e resets to NOP_ALUCTRL.
- Resulting outputs: alu_a = 0, alu_b = 0, storedata_e = 0, stall_d = 0.

Register update (posedge clk, priority order)
- reset.
- flush_e: load a bubble.
- stall_d: load a bubble.
- Otherwise: load all *_d fields; valid_e <= valid_d.
- A bubble means valid, regwrite, memread and memwrite = 0; rd, rs1 and rs2 = 0; alucontrol = NOP_ALUCTRL. Data fields are don't-care but are zeroed.

Load-use hazard (combinational)
- stall_d = memread_e & valid_e & (rd_e != 0) & valid_d & ((rd_e == rs1_d & !alusrca_d) | (rd_e == rs2_d)).
- stall_d is asserted independently of flush_e. Upstream gating by flush is the controller's job.

Forwarding (combinational, from registered rs1_e/rs2_e)
- fwda_e = 2'b10 if exmem_regwrite & exmem_rd != 0 & exmem_rd == rs1_e.
- Otherwise fwda_e = 2'b01 if the same condition holds for memwb.
- Otherwise fwda_e = 2'b00.
- EX/MEM has priority over MEM/WB. x0 is never forwarded.
- fwdb_e is computed identically using rs2_e.
- fwd_rs1 = rs1_data_e, exmem_result or memwb_result according to fwda_e; fwd_rs2 likewise using fwdb_e.

Operand select
- alu_a = alusrca_e ? pc_e : fwd_rs1.
- alu_b = alusrcb_e ? imm_e : fwd_rs2.
- storedata_e = fwd_rs2, regardless of alusrcb_e.

Latency and passthrough
- Latency is one cycle from ID to EX registers.
- Operand outputs are combinational within EX.
- alucontrol_e, rd_e, pc_e, resultsrc_e and the control bits are direct register outputs.

Boundary cases
- Stall for exactly one cycle per load-use: the bubble clears memread_e, which drops stall_d.
- Flush and stall in the same cycle: a single bubble.
- Reset mid-stall: stall_d drops immediately.

Test Plan:
- Reset then release; load add x3,x1,x2 with rs1_data = 5, rs2_data = 7 -> next cycle alu_a = 5, alu_b = 7, alucontrol_e = 0000, fwda/fwdb = 00, valid_e = 1.
- EX/MEM: rd = 1, regwrite = 1, result = 0x10; MEM/WB: rd = 1, result = 0x20; EX instruction has rs1 = 1 -> alu_a = 0x10, fwda_e = 10. Remove EX/MEM -> alu_a = 0x20, fwda_e = 01.
- Forward target x0: exmem_rd = 0, regwrite = 1, result = 0xFF, rs1_e = 0 -> fwda_e = 00, alu_a = rs1_data_e.
- Load-use: EX = lw x5 (memread = 1); ID = add x6,x5,x0 -> stall_d = 1 for one cycle, then a bubble in EX (valid_e = 0, regwrite_e = 0). Next cycle the add enters with fwda_e = 01 from MEM/WB.
- Store: sw x5,8(x1) with alusrcb = 1, imm = 8, exmem_rd = 5 -> alu_b = 8, storedata_e = exmem_result. Also assert flush_e and stall together -> exactly one bubble.
- Assert reset asynchronously mid-cycle with valid_e = 1 -> all outputs go to 0 immediately, without waiting for clk.
